rv_boot_ctrl: RTL and testbench
===============================

Name: rv_boot_ctrl

Overview:
- Boot/reset sequencer and instruction store for the RV32I core. It is the parametrised successor to the fixed single-core top level.
- Receives a program image as a byte stream, writes it into an internal instruction memory and validates it with an XOR checksum.
- Holds the core in reset while loading, then releases it after a programmable hold period.
- Serves the core's instruction fetch port once released. It sits between the board-level top and the core.

Parameters:
- XLEN, 32, width of the fetch address.
- IMEM_DEPTH, 1024, instruction memory depth in 32-bit words; power of two.
- AW, $clog2(IMEM_DEPTH), word-address width (derived, localparam).
- RST_HOLD_CYCLES, 16, cycles the core reset is held low after a good load; valid range ≥1.
- NOP_INSTR, 32'h0000_0013, value returned for out-of-range fetches.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_boot_req  in  1  single-cycle pulse; restarts loading from any state.
- i_rx_data  in  8  image byte.
- i_rx_valid  in  1  byte valid.
- o_rx_ready  out  1  byte accepted when i_rx_valid and o_rx_ready are both high in the same cycle.
- i_fetch_addr  in  XLEN  core byte address.
- o_fetch_instr  out  32  instruction, one-cycle read latency.
- o_core_rst_n  out  1  active-low reset to the core.
- o_boot_busy  out  1  high in LEN/DATA/CSUM/HOLD.
- o_boot_err  out  1  sticky error flag; cleared by i_boot_req or reset.
- o_words_loaded  out  AW+1  words written in the current load.

Behaviour:
- Clock and reset: one clock domain, i_clk. i_rst_n is asynchronous, active-low.
- Reset assertion: all state clears immediately. State = LEN, o_core_rst_n=0, o_rx_ready=0, o_boot_busy=1, o_boot_err=0, o_words_loaded=0, o_fetch_instr=0. Memory contents are not reset.
- Reset release: i_rst_n release passes through a 2-flop synchroniser. o_rx_ready asserts on the 2nd clock edge after the synchronised release.
- Image format (all fields little-endian 32-bit words assembled from 4 bytes, byte 0 first):
  - LEN word N.
  - N data words.
  - CSUM word, which must equal the XOR of all data words (0 if N=0).
- LEN state: collect 4 bytes.
  - N > IMEM_DEPTH → ERROR.
  - N == 0 → CSUM.
  - Otherwise → DATA.
- DATA state:
  - Each complete word is written to IMEM[o_words_loaded]; o_words_loaded increments and the XOR accumulator updates.
  - After word N → CSUM.
  - Memory write occurs in the cycle the 4th byte is accepted.
- CSUM state: collect 4 bytes.
  - Match → HOLD, with the hold counter loaded to RST_HOLD_CYCLES.
  - Mismatch → ERROR.
- HOLD state: decrement each cycle; at 0 → RUN.
- RUN state: o_core_rst_n=1 from the first RUN cycle; o_rx_ready=0; o_boot_busy=0.
- ERROR state: o_boot_err=1, o_core_rst_n=0, o_rx_ready=0. Remains until i_boot_req or reset.
- i_boot_req, any state:
  - Next state LEN; o_core_rst_n=0 on the next edge.
  - Byte counter, word counter and XOR accumulator cleared; o_boot_err cleared.
  - Priority: i_boot_req wins over a byte handshake in the same cycle, and that byte is dropped.
- o_rx_ready is high only in LEN/DATA/CSUM.
- Fetch: word index = i_fetch_addr[AW+1:2]; bits [1:0] are ignored.
  - If i_fetch_addr[XLEN-1:AW+2] ≠ 0, return NOP_INSTR.
  - Registered output, valid 1 cycle after the address.
  - The read port is active in all states; data during a load is undefined.
- Reset mid-load: the partial image is discarded logically (counters clear); the core stays in reset.

Decomposition:
- Package rv_boot_pkg:
  - State enum: LEN, DATA, CSUM, HOLD, RUN, ERROR.
  - Default NOP constant.
  - Byte-lane count constant (4).
- One sub-module, rv_imem_1r1w: a synchronous 1-write/1-read RAM with depth parameter and registered read; inferable as block RAM.
- The 2-flop reset synchroniser stays inline.

Test Plan:
- Good load: N=2, words 0x00500093, 0x00A00113, CSUM 0x00F00180 → after RST_HOLD_CYCLES=16 cycles o_core_rst_n=1. Fetch addr 0x0 → 0x00500093 and 0x4 → 0x00A00113 one cycle later; o_words_loaded=2.
- Bad checksum: same image with CSUM 0x00000000 → o_boot_err=1, o_core_rst_n stays 0, o_rx_ready=0.
- Oversize: LEN=IMEM_DEPTH+1 (1025) → ERROR immediately after the 4th LEN byte; no memory writes (o_words_loaded=0).
- Zero-length: LEN=0, CSUM=0 → RUN after 16 hold cycles.
- Back-pressure and byte gaps: i_rx_valid toggled randomly → same result as the good load.
- Re-boot from RUN: i_boot_req pulse → o_core_rst_n=0 next cycle, o_boot_busy=1.
  - Reload with a new image → new fetch data.
  - Out-of-range fetch 0x0001_0000 → 0x00000013.
- Async reset asserted mid-DATA → outputs at reset values immediately. A following full load succeeds.

Source files
------------

// File: rtl/rv_boot_pkg.sv
// Shared types and constants for the RV32I boot controller and its instruction store.
package rv_boot_pkg;

   typedef enum logic [2:0] {
      S_LEN   = 3'd0,
      S_DATA  = 3'd1,
      S_CSUM  = 3'd2,
      S_HOLD  = 3'd3,
      S_RUN   = 3'd4,
      S_ERROR = 3'd5
   } boot_state_t;

   localparam logic [31:0] DEFAULT_NOP = 32'h0000_0013;
   localparam int          BYTE_LANES  = 4;

endpackage : rv_boot_pkg

// File: rtl/rv_imem_1r1w.sv
// Single-write, single-read synchronous RAM with a registered read port; maps onto block RAM.
module rv_imem_1r1w #(
   parameter int DEPTH = 1024,
   parameter int WIDTH = 32,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rdata;

   // No reset on the array or read register so the tools can infer block RAM.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule : rv_imem_1r1w

// File: rtl/rv_boot_ctrl.sv
// Boot sequencer: loads a length/data/checksum byte stream into instruction memory,
// holds the core in reset until the image verifies, then serves instruction fetches.
module rv_boot_ctrl
   import rv_boot_pkg::*;
#(
   parameter int          XLEN            = 32,
   parameter int          IMEM_DEPTH      = 1024,
   parameter int          RST_HOLD_CYCLES = 16,
   parameter logic [31:0] NOP_INSTR       = DEFAULT_NOP,
   localparam int         AW              = $clog2(IMEM_DEPTH)
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_boot_req,
   input  logic [7:0]      i_rx_data,
   input  logic            i_rx_valid,
   output logic            o_rx_ready,
   input  logic [XLEN-1:0] i_fetch_addr,
   output logic [31:0]     o_fetch_instr,
   output logic            o_core_rst_n,
   output logic            o_boot_busy,
   output logic            o_boot_err,
   output logic [AW:0]     o_words_loaded
);

   localparam int HW = $clog2(RST_HOLD_CYCLES + 1);

   boot_state_t r_state;
   boot_state_t w_next_state;

   logic [1:0]    r_sync;
   logic [1:0]    r_rel_d;
   logic          w_rel;

   logic [1:0]    r_byte_cnt;
   logic [23:0]   r_shift;
   logic [31:0]   r_len;
   logic [AW:0]   r_words;
   logic [31:0]   r_xor;
   logic [HW-1:0] r_hold;

   logic          w_load_state;
   logic          w_fire;
   logic          w_word_done;
   logic [31:0]   w_word;
   logic          w_last_word;
   logic          w_mem_we;

   logic          r_fetch_vld;
   logic          r_fetch_oor;
   logic [31:0]   w_ram_rdata;
   logic          w_unused_addr;

   // Reset release is synchronised, then delayed two more edges before bytes are accepted.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync  <= 2'b00;
         r_rel_d <= 2'b00;
      end else begin
         r_sync  <= {r_sync[0], 1'b1};
         r_rel_d <= {r_rel_d[0], r_sync[1]};
      end
   end

   assign w_rel        = r_rel_d[1];
   assign w_load_state = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CSUM);
   assign o_rx_ready   = w_load_state && w_rel;
   assign w_fire       = i_rx_valid && o_rx_ready && !i_boot_req;
   assign w_word_done  = w_fire && (r_byte_cnt == 2'(BYTE_LANES - 1));
   assign w_word       = {i_rx_data, r_shift};
   assign w_last_word  = ((32'(r_words) + 32'd1) == r_len);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_LEN;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_mem_we     = 1'b0;
      case (r_state)
         S_LEN: begin
            if (w_word_done) begin
               if (w_word > 32'(IMEM_DEPTH)) begin
                  w_next_state = S_ERROR;
               end else if (w_word == 32'd0) begin
                  w_next_state = S_CSUM;
               end else begin
                  w_next_state = S_DATA;
               end
            end
         end
         S_DATA: begin
            w_mem_we = w_word_done;
            if (w_word_done && w_last_word) begin
               w_next_state = S_CSUM;
            end
         end
         S_CSUM: begin
            if (w_word_done) begin
               w_next_state = (w_word == r_xor) ? S_HOLD : S_ERROR;
            end
         end
         S_HOLD: begin
            if (r_hold <= HW'(1)) begin
               w_next_state = S_RUN;
            end
         end
         S_RUN:   w_next_state = S_RUN;
         S_ERROR: w_next_state = S_ERROR;
         default: w_next_state = S_LEN;
      endcase
      if (i_boot_req) begin
         w_next_state = S_LEN;
      end
   end

   // Byte assembly, word counting, checksum and hold countdown; a boot request restarts all of it.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_byte_cnt <= 2'd0;
         r_shift    <= 24'd0;
         r_len      <= 32'd0;
         r_words    <= '0;
         r_xor      <= 32'd0;
         r_hold     <= '0;
      end else if (i_boot_req) begin
         r_byte_cnt <= 2'd0;
         r_shift    <= 24'd0;
         r_len      <= 32'd0;
         r_words    <= '0;
         r_xor      <= 32'd0;
         r_hold     <= '0;
      end else begin
         if (w_fire) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            r_shift    <= {i_rx_data, r_shift[23:8]};
         end
         if (w_word_done && (r_state == S_LEN)) begin
            r_len <= w_word;
         end
         if (w_mem_we) begin
            r_words <= r_words + 1'b1;
            r_xor   <= r_xor ^ w_word;
         end
         if ((r_state == S_CSUM) && (w_next_state == S_HOLD)) begin
            r_hold <= HW'(RST_HOLD_CYCLES);
         end else if ((r_state == S_HOLD) && (r_hold != '0)) begin
            r_hold <= r_hold - 1'b1;
         end
      end
   end

   assign o_core_rst_n   = (r_state == S_RUN);
   assign o_boot_busy    = w_load_state || (r_state == S_HOLD);
   assign o_boot_err     = (r_state == S_ERROR);
   assign o_words_loaded = r_words;

   rv_imem_1r1w #(
      .DEPTH (IMEM_DEPTH),
      .WIDTH (32)
   ) u_imem (
      .i_clk   (i_clk),
      .i_we    (w_mem_we),
      .i_waddr (r_words[AW-1:0]),
      .i_wdata (w_word),
      .i_raddr (i_fetch_addr[AW+1:2]),
      .o_rdata (w_ram_rdata)
   );

   // The out-of-range flag is registered alongside the RAM read so both line up.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_fetch_vld <= 1'b0;
         r_fetch_oor <= 1'b0;
      end else begin
         r_fetch_vld <= 1'b1;
         r_fetch_oor <= |i_fetch_addr[XLEN-1:AW+2];
      end
   end

   assign o_fetch_instr = !r_fetch_vld ? 32'd0 :
                          r_fetch_oor  ? NOP_INSTR : w_ram_rdata;

   assign w_unused_addr = ^i_fetch_addr[1:0];

endmodule : rv_boot_ctrl

// File: tb/tb_rv_boot_ctrl.sv
// Directed testbench for rv_boot_ctrl: table of boot images and fetches plus hand-written
// sequences for reset release, boot-request priority and asynchronous reset mid-load.
module tb_rv_boot_ctrl;

   logic        clk;
   logic        rstN;
   logic        bootReq;
   logic [7:0]  rxData;
   logic        rxValid;
   logic        rxReady;
   logic [31:0] fetchAddr;
   logic [31:0] fetchInstr;
   logic        coreRstN;
   logic        bootBusy;
   logic        bootErr;
   logic [10:0] wordsLoaded;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] len;
      logic [31:0] w0;
      logic [31:0] w1;
      logic [31:0] csum;
      bit          gaps;
      bit          expErr;
      int          expWords;
   } image_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] instr;
   } fetch_t;

   image_t images [6];
   fetch_t fetches [6];

   rv_boot_ctrl #(
      .XLEN            (32),
      .IMEM_DEPTH      (1024),
      .RST_HOLD_CYCLES (16),
      .NOP_INSTR       (32'h0000_0013)
   ) dut (
      .i_clk          (clk),
      .i_rst_n        (rstN),
      .i_boot_req     (bootReq),
      .i_rx_data      (rxData),
      .i_rx_valid     (rxValid),
      .o_rx_ready     (rxReady),
      .i_fetch_addr   (fetchAddr),
      .o_fetch_instr  (fetchInstr),
      .o_core_rst_n   (coreRstN),
      .o_boot_busy    (bootBusy),
      .o_boot_err     (bootErr),
      .o_words_loaded (wordsLoaded)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic stepClock(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Present one byte and hold it until the handshake edge, bounded by a cycle budget.
   task automatic applyStimulus(input logic [7:0] b, input bit gaps);
      bit done;
      done = 1'b0;
      if (gaps) begin
         rxValid = 1'b0;
         stepClock($urandom_range(0, 2));
      end
      rxData  = b;
      rxValid = 1'b1;
      for (int k = 0; k < 50 && !done; k++) begin
         if (rxReady) begin
            done = 1'b1;
         end
         stepClock(1);
      end
      rxValid = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("[TB] FAIL rx handshake timeout: got ready=0, expected ready=1");
      end
   endtask

   task automatic sendWord(input logic [31:0] w, input bit gaps);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(w[8*i +: 8], gaps);
      end
   endtask

   task automatic pulseBootReq();
      bootReq = 1'b1;
      stepClock(1);
      bootReq = 1'b0;
      checkOutput("bootreq core_rst_n", 32'(coreRstN), 32'd0);
      checkOutput("bootreq busy", 32'(bootBusy), 32'd1);
      checkOutput("bootreq err", 32'(bootErr), 32'd0);
      checkOutput("bootreq words", 32'(wordsLoaded), 32'd0);
   endtask

   task automatic fetchCheck(input string name, input logic [31:0] addr, input logic [31:0] expected);
      fetchAddr = addr;
      stepClock(1);
      checkOutput(name, fetchInstr, expected);
   endtask

   task automatic runImage(input image_t v);
      sendWord(v.len, v.gaps);
      if (v.len > 32'd1024) begin
         checkOutput("oversize err", 32'(bootErr), 32'd1);
         checkOutput("oversize words", 32'(wordsLoaded), 32'd0);
         checkOutput("oversize ready", 32'(rxReady), 32'd0);
         checkOutput("oversize core_rst_n", 32'(coreRstN), 32'd0);
         return;
      end
      if (v.len >= 32'd1) sendWord(v.w0, v.gaps);
      if (v.len >= 32'd2) sendWord(v.w1, v.gaps);
      sendWord(v.csum, v.gaps);
      checkOutput("words loaded", 32'(wordsLoaded), 32'(v.expWords));
      if (v.expErr) begin
         checkOutput("csum err", 32'(bootErr), 32'd1);
         checkOutput("csum err ready", 32'(rxReady), 32'd0);
         stepClock(20);
         checkOutput("csum err core_rst_n", 32'(coreRstN), 32'd0);
      end else begin
         stepClock(14);
         checkOutput("hold core_rst_n", 32'(coreRstN), 32'd0);
         checkOutput("hold busy", 32'(bootBusy), 32'd1);
         stepClock(2);
         checkOutput("run core_rst_n", 32'(coreRstN), 32'd1);
         checkOutput("run busy", 32'(bootBusy), 32'd0);
         checkOutput("run ready", 32'(rxReady), 32'd0);
         checkOutput("run err", 32'(bootErr), 32'd0);
         if (v.len == 32'd2) begin
            fetchCheck("fetch word0", 32'h0, v.w0);
            fetchCheck("fetch word1", 32'h4, v.w1);
         end
      end
   endtask

   initial begin
      images[0] = '{32'd2,    32'h0050_0093, 32'h00A0_0113, 32'h00F0_0180, 1'b0, 1'b0, 2};
      images[1] = '{32'd2,    32'h0050_0093, 32'h00A0_0113, 32'h0000_0000, 1'b0, 1'b1, 2};
      images[2] = '{32'd1025, 32'h0,         32'h0,         32'h0,         1'b0, 1'b1, 0};
      images[3] = '{32'd0,    32'h0,         32'h0,         32'h0000_0000, 1'b0, 1'b0, 0};
      images[4] = '{32'd2,    32'h0050_0093, 32'h00A0_0113, 32'h00F0_0180, 1'b1, 1'b0, 2};
      images[5] = '{32'd2,    32'h1234_5678, 32'hCAFE_F00D, 32'hD8CA_A675, 1'b0, 1'b0, 2};

      fetches[0] = '{32'h0000_0000, 32'h1234_5678};
      fetches[1] = '{32'h0000_0004, 32'hCAFE_F00D};
      fetches[2] = '{32'h0000_0006, 32'hCAFE_F00D};
      fetches[3] = '{32'h0001_0000, 32'h0000_0013};
      fetches[4] = '{32'hFFFF_FFFC, 32'h0000_0013};
      fetches[5] = '{32'h0000_1000, 32'h0000_0013};

      rstN      = 1'b0;
      bootReq   = 1'b0;
      rxData    = 8'h00;
      rxValid   = 1'b0;
      fetchAddr = 32'h0;

      stepClock(3);
      checkOutput("reset core_rst_n", 32'(coreRstN), 32'd0);
      checkOutput("reset ready", 32'(rxReady), 32'd0);
      checkOutput("reset busy", 32'(bootBusy), 32'd1);
      checkOutput("reset err", 32'(bootErr), 32'd0);
      checkOutput("reset words", 32'(wordsLoaded), 32'd0);
      checkOutput("reset fetch", fetchInstr, 32'd0);

      rstN = 1'b1;
      stepClock(1);
      checkOutput("release ready early", 32'(rxReady), 32'd0);
      stepClock(3);
      checkOutput("release ready", 32'(rxReady), 32'd1);

      $display("[TB] image table");
      for (int i = 0; i < 6; i++) begin
         if (i != 0) pulseBootReq();
         runImage(images[i]);
      end

      $display("[TB] fetch table");
      for (int i = 0; i < 6; i++) begin
         fetchCheck("fetch table", fetches[i].addr, fetches[i].instr);
      end

      $display("[TB] boot request beats a simultaneous byte");
      bootReq = 1'b1;
      rxData  = 8'hAA;
      rxValid = 1'b1;
      stepClock(1);
      bootReq = 1'b0;
      rxValid = 1'b0;
      checkOutput("priority core_rst_n", 32'(coreRstN), 32'd0);
      runImage(images[0]);

      $display("[TB] async reset mid-load");
      pulseBootReq();
      sendWord(32'd2, 1'b0);
      sendWord(32'h0050_0093, 1'b0);
      applyStimulus(8'h13, 1'b0);
      applyStimulus(8'h01, 1'b0);
      checkOutput("midload words", 32'(wordsLoaded), 32'd1);
      rstN = 1'b0;
      #1;
      checkOutput("async core_rst_n", 32'(coreRstN), 32'd0);
      checkOutput("async ready", 32'(rxReady), 32'd0);
      checkOutput("async busy", 32'(bootBusy), 32'd1);
      checkOutput("async err", 32'(bootErr), 32'd0);
      checkOutput("async words", 32'(wordsLoaded), 32'd0);
      checkOutput("async fetch", fetchInstr, 32'd0);
      stepClock(2);
      rstN = 1'b1;
      stepClock(4);
      runImage(images[5]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_rv_boot_ctrl
